alu_cmd_sequencer: RTL and testbench

//  Upstream front-end for the 6-bit 16-op ALU core. Assembles tagged input bytes into
//  one command (operand A, operand B, opcode) and issues it with a start pulse. It then

---
 rtl/alu_cmd_sequencer_if.sv | 44 ++++
 rtl/alu_cmd_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer_if
//   Bundles every non-clock/reset signal of the ALU command sequencer:
//   - the tagged byte input stream (in_valid / in_ready / in_data),
//   - the command and response port toward the ALU core (alu_*),
//   - the result output stream (out_valid / out_ready / out_*),
//   - the status signals frame_err and op_count.
//   master : the sequencer side (drives in_ready, alu_a/b/op/start, out_*, status)
//   slave  : the environment side (byte producer, ALU core, result consumer)
// -----------------------------------------------------------------------------
interface alu_cmd_sequencer_if #(
    parameter int DW  = 6,
    parameter int OPW = 4,
    parameter int FW  = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [7:0]     in_data;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_op;
    logic           alu_start;
    logic           alu_done;
    logic [DW-1:0]  alu_result;
    logic [FW-1:0]  alu_flags;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_result;
    logic [FW-1:0]  out_flags;
    logic           frame_err;
    logic [7:0]     op_count;

    modport master (
        input  in_valid, in_data, alu_done, alu_result, alu_flags, out_ready,
        output in_ready, alu_a, alu_b, alu_op, alu_start,
               out_valid, out_result, out_flags, frame_err, op_count
    );

    modport slave (
        output in_valid, in_data, alu_done, alu_result, alu_flags, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, alu_start,
               out_valid, out_result, out_flags, frame_err, op_count
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//   Front-end for a small ALU core. Collects tagged bytes (01=A, 10=B, 11=OP,
//   00=idle) into one command, issues it with a single-cycle alu_start, waits
//   for alu_done (bounded by TIMEOUT cycles), captures result/flags and offers
//   them on a valid/ready output. Counts completed operations (8-bit, wraps).
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : alu_cmd_sequencer_if.master (byte input, ALU port, result output,
//          frame_err pulse, op_count)
// Parameters
//   DW (<= 6, must fit a byte payload), OPW, FW, TIMEOUT (>= 1)
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int DW      = 6,
    parameter int OPW     = 4,
    parameter int FW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_sequencer_if.master bus
);
    // Timeout counter runs 0..TIMEOUT-1 while waiting for the ALU.
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] TAG_A  = 2'b01;
    localparam logic [1:0] TAG_B  = 2'b10;
    localparam logic [1:0] TAG_OP = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_ISSUE,
        S_WAIT_RES,
        S_OUTPUT
    } state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  a_q, a_d;
    logic [DW-1:0]  b_q, b_d;
    logic [OPW-1:0] op_q, op_d;
    logic [DW-1:0]  res_q, res_d;
    logic [FW-1:0]  flags_q, flags_d;
    logic           err_q, err_d;
    logic [7:0]     ops_q, ops_d;
    logic [CW-1:0]  tmo_q, tmo_d;

    logic           in_ready;
    logic           accept;
    logic [1:0]     tag;
    logic           op_payload_ok;

    assign in_ready      = (state_q == S_WAIT_A) || (state_q == S_WAIT_B) ||
                           (state_q == S_WAIT_OP);
    assign accept        = bus.in_valid & in_ready;
    assign tag           = bus.in_data[7:6];
    // Opcode bytes must carry zeros above the 4-bit opcode field.
    assign op_payload_ok = (bus.in_data[5:4] == 2'b00);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flags_d = flags_q;
        err_d   = 1'b0;
        ops_d   = ops_q;
        tmo_d   = tmo_q;

        case (state_q)
            S_WAIT_A: begin
                if (accept) begin
                    if (tag == TAG_A) begin
                        a_d     = bus.in_data[DW-1:0];
                        state_d = S_WAIT_B;
                    end else if (tag != 2'b00) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT_B: begin
                if (accept) begin
                    case (tag)
                        TAG_B: begin
                            b_d     = bus.in_data[DW-1:0];
                            state_d = S_WAIT_OP;
                        end
                        // A repeated A restarts the frame with the new operand.
                        TAG_A: begin
                            a_d   = bus.in_data[DW-1:0];
                            err_d = 1'b1;
                        end
                        TAG_OP: begin
                            err_d   = 1'b1;
                            state_d = S_WAIT_A;
                        end
                        default: ;
                    endcase
                end
            end
            S_WAIT_OP: begin
                if (accept) begin
                    case (tag)
                        TAG_OP: begin
                            if (op_payload_ok) begin
                                op_d    = bus.in_data[OPW-1:0];
                                state_d = S_ISSUE;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_WAIT_A;
                            end
                        end
                        TAG_A: begin
                            a_d     = bus.in_data[DW-1:0];
                            err_d   = 1'b1;
                            state_d = S_WAIT_B;
                        end
                        TAG_B: begin
                            err_d   = 1'b1;
                            state_d = S_WAIT_A;
                        end
                        default: ;
                    endcase
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                // Done wins over timeout when both land on the last cycle.
                if (bus.alu_done) begin
                    res_d   = bus.alu_result;
                    flags_d = bus.alu_flags;
                    ops_d   = ops_q + 8'd1;
                    state_d = S_OUTPUT;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_WAIT_A;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            S_OUTPUT: begin
                if (bus.out_ready) begin
                    state_d = S_WAIT_A;
                end
            end
            default: state_d = S_WAIT_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
            ops_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            err_q   <= err_d;
            ops_q   <= ops_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.alu_start  = (state_q == S_ISSUE);
    assign bus.out_valid  = (state_q == S_OUTPUT);
    assign bus.out_result = res_q;
    assign bus.out_flags  = flags_q;
    assign bus.frame_err  = err_q;
    assign bus.op_count   = ops_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//   Drives tagged bytes, plays the ALU core and the result consumer, and
//   compares the sequencer against a frame-level reference model
//   (which fields of the current frame have been collected, latched values,
//   completed-op count).
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;
    localparam int DW      = 6;
    localparam int OPW     = 4;
    localparam int FW      = 4;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.DW(DW), .OPW(OPW), .FW(FW)) bus ();

    alu_cmd_sequencer #(.DW(DW), .OPW(OPW), .FW(FW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         m_have_a, m_have_b;
    logic [5:0] m_a, m_b, m_res;
    logic [3:0] m_op, m_flags;
    int         m_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_have_a = 0; m_have_b = 0;
        m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_flags = '0;
        m_count = 0;
    endtask

    // Stand-in ALU behaviour: {flags, result}
    function automatic logic [9:0] alu_fn(input logic [5:0] a, input logic [5:0] b,
                                          input logic [3:0] op);
        logic [5:0] r;
        logic [3:0] f;
        case (op)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd3:    r = a - b;
            default: r = a ^ b ^ {2'b00, op};
        endcase
        f = {op[3], (r == '0), op[1] & op[0], r[5]};
        return {f, r};
    endfunction

    // Frame rules applied to one accepted byte
    task automatic model_byte(input logic [7:0] b, output bit err, output bit issue);
        logic [1:0] t;
        logic [5:0] p;
        t = b[7:6];
        p = b[5:0];
        err = 0;
        issue = 0;
        if (t == 2'b00) return;
        if (!m_have_a) begin
            if (t == 2'b01) begin m_a = p; m_have_a = 1; end
            else err = 1;
        end else if (!m_have_b) begin
            if (t == 2'b10) begin m_b = p; m_have_b = 1; end
            else if (t == 2'b01) begin m_a = p; err = 1; end
            else begin err = 1; m_have_a = 0; end
        end else begin
            if (t == 2'b11 && p[5:4] == 2'b00) begin
                m_op = p[3:0]; issue = 1; m_have_a = 0; m_have_b = 0;
            end else if (t == 2'b01) begin
                m_a = p; m_have_b = 0; err = 1;
            end else begin
                err = 1; m_have_a = 0; m_have_b = 0;
            end
        end
    endtask

    function automatic logic [7:0] pick_byte();
        logic [7:0] r;
        r = 8'($urandom);
        if ($urandom_range(0, 3) == 0) return r;
        if (!m_have_a) return {2'b01, r[5:0]};
        if (!m_have_b) return {2'b10, r[5:0]};
        return {4'b1100, r[3:0]};
    endfunction

    // Entered at #1 after the edge that moved the DUT into ISSUE.
    task automatic run_op(input int delay, input int stall);
        logic [9:0] r;
        bus.alu_done   = 1'b1;            // must be ignored in ISSUE
        bus.alu_result = 6'($urandom);
        bus.alu_flags  = 4'($urandom);
        @(posedge clk); #1;               // first WAIT_RES cycle
        chk("start_one_cycle", 32'(bus.alu_start), 0);
        bus.alu_done = 1'b0;
        r = alu_fn(m_a, m_b, m_op);
        if (delay < TIMEOUT) begin
            repeat (delay) begin
                @(posedge clk); #1;
                chk("err_while_waiting", 32'(bus.frame_err), 0);
                chk("valid_while_waiting", 32'(bus.out_valid), 0);
            end
            bus.alu_done   = 1'b1;
            bus.alu_result = r[5:0];
            bus.alu_flags  = r[9:6];
            @(posedge clk); #1;
            bus.alu_done   = 1'b0;
            bus.alu_result = 6'($urandom);
            bus.alu_flags  = 4'($urandom);
            m_count = (m_count + 1) % 256;
            m_res   = r[5:0];
            m_flags = r[9:6];
            chk("out_valid", 32'(bus.out_valid), 1);
            chk("out_result", 32'(bus.out_result), 32'(m_res));
            chk("out_flags", 32'(bus.out_flags), 32'(m_flags));
            chk("op_count", 32'(bus.op_count), m_count);
            chk("err_on_done", 32'(bus.frame_err), 0);
            chk("in_ready_output", 32'(bus.in_ready), 0);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            repeat (stall) begin
                @(posedge clk); #1;
                chk("stall_valid", 32'(bus.out_valid), 1);
                chk("stall_result", 32'(bus.out_result), 32'(m_res));
                chk("stall_flags", 32'(bus.out_flags), 32'(m_flags));
                chk("stall_in_ready", 32'(bus.in_ready), 0);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            chk("drain_valid", 32'(bus.out_valid), 0);
            chk("drain_in_ready", 32'(bus.in_ready), 1);
        end else begin
            for (int i = 1; i <= TIMEOUT; i++) begin
                @(posedge clk); #1;
                chk("timeout_err", 32'(bus.frame_err), 32'(i == TIMEOUT));
                chk("timeout_valid", 32'(bus.out_valid), 0);
            end
            chk("timeout_count", 32'(bus.op_count), m_count);
            chk("timeout_result", 32'(bus.out_result), 32'(m_res));
            chk("timeout_in_ready", 32'(bus.in_ready), 1);
        end
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic do_byte(input logic [7:0] b, input int delay, input int stall);
        bit err, issue;
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (!bus.in_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) chk("in_ready_bound", 32'(bus.in_ready), 1);
        bus.alu_done   = 1'($urandom);    // must be ignored in WAIT_* states
        bus.alu_result = 6'($urandom);
        bus.alu_flags  = 4'($urandom);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.alu_done = 1'b0;
        model_byte(b, err, issue);
        chk("frame_err", 32'(bus.frame_err), 32'(err));
        chk("alu_a", 32'(bus.alu_a), 32'(m_a));
        chk("alu_b", 32'(bus.alu_b), 32'(m_b));
        chk("alu_op", 32'(bus.alu_op), 32'(m_op));
        chk("alu_start", 32'(bus.alu_start), 32'(issue));
        chk("in_ready_after", 32'(bus.in_ready), 32'(!issue));
        if (issue) run_op(delay, stall);
    endtask

    task automatic fast_op();
        do_byte({2'b01, 6'($urandom)}, 0, 0);
        do_byte({2'b10, 6'($urandom)}, 0, 0);
        do_byte({4'b1100, 4'($urandom)}, 0, 0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.alu_done  = 1'b0;
        bus.alu_result = '0;
        bus.alu_flags = '0;
        bus.out_ready = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("rst_alu_start", 32'(bus.alu_start), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_op_count", 32'(bus.op_count), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        // Reset in the middle of a frame
        do_byte(8'h45, 0, 0);
        do_byte(8'h83, 0, 0);
        rst = 1'b1;
        #2;
        model_reset();
        chk("midrst_alu_a", 32'(bus.alu_a), 0);
        chk("midrst_alu_b", 32'(bus.alu_b), 0);
        chk("midrst_frame_err", 32'(bus.frame_err), 0);
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 1);

        // Basic op: 5 + 3
        do_byte(8'h45, 0, 0);
        do_byte(8'h83, 0, 0);
        do_byte(8'hC2, 0, 0);
        chk("t2_result", 32'(bus.out_result), 8);
        chk("t2_flags", 32'(bus.out_flags), 0);
        chk("t2_count", 32'(bus.op_count), 1);

        // Out-of-order B in WAIT_A, then bad opcode payload
        do_byte(8'h83, 0, 0);
        do_byte(8'h45, 0, 0);
        do_byte(8'h83, 0, 0);
        do_byte(8'hF2, 0, 0);

        // Timeout, then done on the last allowed cycle, then a long stall
        do_byte(8'h4A, 0, 0); do_byte(8'h91, 0, 0); do_byte(8'hC1, TIMEOUT, 0);
        do_byte(8'h4A, 0, 0); do_byte(8'h91, 0, 0); do_byte(8'hC1, TIMEOUT - 1, 0);
        do_byte(8'h7F, 0, 0); do_byte(8'hBF, 0, 0); do_byte(8'hC3, 0, 10);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            do_byte(pick_byte(), int'($urandom_range(0, TIMEOUT + 1)),
                    int'($urandom_range(0, 3)));
        end

        // Wrap op_count back to 0
        begin
            int need;
            need = (256 - m_count) % 256;
            if (need == 0) need = 256;
            for (int i = 0; i < need; i++) fast_op();
            chk("count_wrap", 32'(bus.op_count), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
